// File: rtl/y86_pkg.sv
// Shared types for the register-file write scheduler.
// Register ids, the cmov opcode, write records and debug FSM states.
package y86_pkg;

   localparam logic [3:0] RNONE  = 4'hF;
   localparam logic [3:0] I_CMOV = 4'h2;

   typedef struct packed {
      logic [3:0]  addr;
      logic [63:0] data;
   } wr_t;

   typedef enum logic [1:0] {
      DBG_IDLE,
      DBG_WAIT,
      DBG_FORCE
   } dbg_st_t;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// W-stage bundle into the write scheduler.
// The W stage drives the bundle; the scheduler answers with stall.
interface regfile_wr_sched_if #(
   parameter int DW = 64
);
   logic          w_valid;
   logic [3:0]    W_icode;
   logic          W_Cnd;
   logic [3:0]    W_dstE;
   logic [DW-1:0] W_valE;
   logic [3:0]    W_dstM;
   logic [DW-1:0] W_valM;
   logic          w_stall;

   modport master (
      output w_valid, W_icode, W_Cnd,
      output W_dstE, W_valE, W_dstM, W_valM,
      input  w_stall
   );

   modport slave (
      input  w_valid, W_icode, W_Cnd,
      input  W_dstE, W_valE, W_dstM, W_valM,
      output w_stall
   );
endinterface

// File: rtl/regfile_wr_sched_queue.sv
// Pending-write FIFO: two pushes and one pop per cycle.
// Lookup scans oldest to youngest so the youngest match wins.
module wr_queue #(
   parameter  int DEPTH = 2,
   parameter  int DW    = 64,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push0,
   input  logic [3:0]    push0_addr,
   input  logic [DW-1:0] push0_data,
   input  logic          push1,
   input  logic [3:0]    push1_addr,
   input  logic [DW-1:0] push1_data,
   input  logic          pop,
   output logic [3:0]    head_addr,
   output logic [DW-1:0] head_data,
   output logic [CW-1:0] count,
   input  logic [3:0]    lk_addr,
   output logic          lk_hit,
   output logic [DW-1:0] lk_data
);

   logic [3:0]    addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] cnt;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (pop)
            rd_ptr <= inc(rd_ptr);
         if (push1)
            wr_ptr <= inc(inc(wr_ptr));
         else if (push0)
            wr_ptr <= inc(wr_ptr);
         cnt <= cnt + CW'(push0) + CW'(push1) - CW'(pop);
      end
   end

   // entry storage; contents are don't-care until counted
   always_ff @(posedge clk) begin
      if (push0) begin
         addr_q[wr_ptr] <= push0_addr;
         data_q[wr_ptr] <= push0_data;
      end
      if (push1) begin
         addr_q[inc(wr_ptr)] <= push1_addr;
         data_q[inc(wr_ptr)] <= push1_data;
      end
   end

   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   assign count     = cnt;

   // CAM search, later (younger) matches override earlier ones
   always_comb begin
      int            j;
      logic [PW-1:0] p;
      j       = 0;
      p       = '0;
      lk_hit  = 1'b0;
      lk_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         j = int'(rd_ptr) + i;
         if (j >= DEPTH)
            j = j - DEPTH;
         p = PW'(j);
         if (i < int'(cnt) && addr_q[p] == lk_addr) begin
            lk_hit  = 1'b1;
            lk_data = data_q[p];
         end
      end
   end

endmodule

// File: rtl/regfile_wr_sched.sv
// Serialises W-stage E/M writes and debug writes onto one RF port.
// Holds the issue mux, stall logic, debug starvation FSM and RF regs.
module regfile_wr_sched
   import y86_pkg::*;
#(
   parameter  int DEPTH  = 2,
   parameter  int DW     = 64,
   parameter  int STARVE = 8,
   localparam int CW     = $clog2(DEPTH + 1),
   localparam int SW     = $clog2(STARVE + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   regfile_wr_sched_if.slave w,
   input  logic             dbg_req,
   input  logic [3:0]       dbg_addr,
   input  logic [DW-1:0]    dbg_data,
   output logic             dbg_gnt,
   output logic             rf_we,
   output logic [3:0]       rf_waddr,
   output logic [DW-1:0]    rf_wdata,
   input  logic [3:0]       lk_addr,
   output logic             lk_hit,
   output logic [DW-1:0]    lk_data,
   output logic [CW-1:0]    q_count
);

   dbg_st_t       st, st_n;
   logic [SW-1:0] cnt, cnt_n;

   logic          stall, acc, en;
   logic          e_wr, m_wr, dbg_wr;
   logic          q_empty, q_full;

   logic          push0, push1, pop;
   logic [3:0]    p0_addr, p1_addr;
   logic [DW-1:0] p0_data, p1_data;
   logic [3:0]    head_addr;
   logic [DW-1:0] head_data;
   logic          q_hit;
   logic [DW-1:0] q_data;

   logic          iss_we;
   logic [3:0]    iss_addr;
   logic [DW-1:0] iss_data;

   assign q_empty   = (q_count == '0);
   assign q_full    = (q_count == CW'(DEPTH));
   assign stall     = q_full || (st == DBG_FORCE);
   assign w.w_stall = stall;

   assign acc  = w.w_valid && !stall;
   assign en   = (w.W_icode != I_CMOV) || w.W_Cnd;
   assign e_wr = acc && en && (w.W_dstE != RNONE);
   assign m_wr = acc && en && (w.W_dstM != RNONE);

   assign dbg_gnt = dbg_req && q_empty && !e_wr && !m_wr;
   assign dbg_wr  = dbg_gnt && (dbg_addr != RNONE);

   wr_queue #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_q (
      .clk        (clk),
      .rst_n      (rst_n),
      .push0      (push0),
      .push0_addr (p0_addr),
      .push0_data (p0_data),
      .push1      (push1),
      .push1_addr (p1_addr),
      .push1_data (p1_data),
      .pop        (pop),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .count      (q_count),
      .lk_addr    (lk_addr),
      .lk_hit     (q_hit),
      .lk_data    (q_data)
   );

   // oldest candidate issues; younger accepted writes queue in order
   always_comb begin
      iss_we   = 1'b0;
      iss_addr = 4'h0;
      iss_data = '0;
      pop      = 1'b0;
      push0    = 1'b0;
      push1    = 1'b0;
      p0_addr  = 4'h0;
      p0_data  = '0;
      p1_addr  = w.W_dstM;
      p1_data  = w.W_valM;
      if (!q_empty) begin
         iss_we   = 1'b1;
         iss_addr = head_addr;
         iss_data = head_data;
         pop      = 1'b1;
         push0    = e_wr || m_wr;
         push1    = e_wr && m_wr;
         p0_addr  = e_wr ? w.W_dstE : w.W_dstM;
         p0_data  = e_wr ? w.W_valE : w.W_valM;
      end else if (e_wr) begin
         iss_we   = 1'b1;
         iss_addr = w.W_dstE;
         iss_data = w.W_valE;
         push0    = m_wr;
         p0_addr  = w.W_dstM;
         p0_data  = w.W_valM;
      end else if (m_wr) begin
         iss_we   = 1'b1;
         iss_addr = w.W_dstM;
         iss_data = w.W_valM;
      end else if (dbg_wr) begin
         iss_we   = 1'b1;
         iss_addr = dbg_addr;
         iss_data = dbg_data;
      end
   end

   // registered write port; address/data hold when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= RNONE;
         rf_wdata <= '0;
      end else begin
         rf_we <= iss_we;
         if (iss_we) begin
            rf_waddr <= iss_addr;
            rf_wdata <= iss_data;
         end
      end
   end

   // debug FSM state and starvation counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st  <= DBG_IDLE;
         cnt <= '0;
      end else begin
         st  <= st_n;
         cnt <= cnt_n;
      end
   end

   // starvation tracking: count ungranted request cycles
   always_comb begin
      st_n  = st;
      cnt_n = cnt;
      unique case (st)
         DBG_IDLE: begin
            if (dbg_req && !dbg_gnt) begin
               cnt_n = SW'(1);
               st_n  = (STARVE <= 1) ? DBG_FORCE : DBG_WAIT;
            end
         end
         DBG_WAIT: begin
            if (dbg_gnt || !dbg_req) begin
               st_n  = DBG_IDLE;
               cnt_n = '0;
            end else if (int'(cnt) + 1 >= STARVE) begin
               st_n  = DBG_FORCE;
               cnt_n = SW'(STARVE);
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DBG_FORCE: begin
            if (dbg_gnt) begin
               st_n  = DBG_IDLE;
               cnt_n = '0;
            end
         end
         default: begin
            st_n  = DBG_IDLE;
            cnt_n = '0;
         end
      endcase
   end

   // youngest pending value: queue first, then the RF output register
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      if (lk_addr != RNONE) begin
         if (q_hit) begin
            lk_hit  = 1'b1;
            lk_data = q_data;
         end else if (rf_we && rf_waddr == lk_addr) begin
            lk_hit  = 1'b1;
            lk_data = rf_wdata;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Bench for regfile_wr_sched: directed cases plus random traffic.
// A queue-based model predicts every output on every cycle.
module tb_regfile_wr_sched;

   localparam int DEPTH  = 2;
   localparam int STARVE = 8;

   typedef struct {
      logic [3:0]  a;
      logic [63:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dbg_req = 1'b0;
   logic [3:0]  dbg_addr = 4'h0;
   logic [63:0] dbg_data = '0;
   logic        dbg_gnt;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic [3:0]  lk_addr = 4'hF;
   logic        lk_hit;
   logic [63:0] lk_data;
   logic [1:0]  q_count;

   regfile_wr_sched_if #(.DW(64)) w ();

   regfile_wr_sched #(
      .DEPTH  (DEPTH),
      .DW     (64),
      .STARVE (STARVE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .w        (w),
      .dbg_req  (dbg_req),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .dbg_gnt  (dbg_gnt),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .lk_addr  (lk_addr),
      .lk_hit   (lk_hit),
      .lk_data  (lk_data),
      .q_count  (q_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   ent_t        mq[$];
   ent_t        nxt[$];
   ent_t        log_q[$];
   logic        m_we = 1'b0;
   logic [3:0]  m_addr = 4'hF;
   logic [63:0] m_data = '0;
   int          streak = 0;
   bit          stall_last = 0;
   bit          gnt_last = 0;

   always @(negedge clk) begin
      bit          x_stall, x_gnt, acc, en, x_hit;
      logic [63:0] x_lk;
      ent_t        e;
      if (!rst_n) begin
         mq.delete();
         m_we = 1'b0; m_addr = 4'hF; m_data = '0;
         streak = 0; stall_last = 0; gnt_last = 0;
         chk("rst_rf_we", rf_we, 0);
         chk("rst_rf_waddr", rf_waddr, 4'hF);
         chk("rst_rf_wdata", rf_wdata, 0);
         chk("rst_q_count", q_count, 0);
         chk("rst_w_stall", w.w_stall, 0);
         chk("rst_dbg_gnt", dbg_gnt, 0);
      end else begin
         x_stall = (mq.size() == DEPTH) || (streak >= STARVE);
         acc = w.w_valid && !x_stall;
         en = (w.W_icode != 4'h2) || w.W_Cnd;
         nxt = mq;
         if (acc && en && w.W_dstE != 4'hF) begin
            e.a = w.W_dstE; e.d = w.W_valE; nxt.push_back(e);
         end
         if (acc && en && w.W_dstM != 4'hF) begin
            e.a = w.W_dstM; e.d = w.W_valM; nxt.push_back(e);
         end
         x_gnt = dbg_req && mq.size() == 0 && nxt.size() == 0;
         x_hit = 0; x_lk = '0;
         if (lk_addr != 4'hF) begin
            if (m_we && m_addr == lk_addr) begin
               x_hit = 1; x_lk = m_data;
            end
            foreach (mq[i])
               if (mq[i].a == lk_addr) begin
                  x_hit = 1; x_lk = mq[i].d;
               end
         end
         chk("w_stall", w.w_stall, x_stall);
         chk("dbg_gnt", dbg_gnt, x_gnt);
         chk("rf_we", rf_we, m_we);
         chk("rf_waddr", rf_waddr, m_addr);
         chk("rf_wdata", rf_wdata, m_data);
         chk("q_count", q_count, mq.size());
         chk("q_bound", q_count <= DEPTH, 1);
         chk("lk_hit", lk_hit, x_hit);
         chk("lk_data", lk_data, x_lk);
         if (rf_we) begin
            e.a = rf_waddr; e.d = rf_wdata; log_q.push_back(e);
         end
         if (x_gnt && dbg_addr != 4'hF) begin
            e.a = dbg_addr; e.d = dbg_data; nxt.push_back(e);
         end
         if (nxt.size() > 0) begin
            e = nxt.pop_front();
            m_we = 1'b1; m_addr = e.a; m_data = e.d;
         end else begin
            m_we = 1'b0;
         end
         mq = nxt;
         streak = (dbg_req && !x_gnt) ? streak + 1 : 0;
         stall_last = x_stall;
         gnt_last = x_gnt;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      w.w_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic send(input logic [3:0] ic, input logic c,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       output bit stalled);
      int n;
      w.w_valid = 1'b1; w.W_icode = ic; w.W_Cnd = c;
      w.W_dstE = de; w.W_valE = ve; w.W_dstM = dm; w.W_valM = vm;
      #1;
      stalled = 0;
      n = 0;
      while (w.w_stall && n < 40) begin
         stalled = 1;
         step();
         n++;
      end
      if (n == 40)
         chk("send_timeout", 1, 0);
      step();
   endtask

   bit s1, s2, s3;
   bit stop;
   int n, k;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      w.w_valid = 0; w.W_icode = 0; w.W_Cnd = 0;
      w.W_dstE = 4'hF; w.W_valE = 0; w.W_dstM = 4'hF; w.W_valM = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // popq-style bundle
      w.w_valid = 1; w.W_icode = 4'hB; w.W_Cnd = 0;
      w.W_dstE = 4'h4; w.W_valE = 64'h108;
      w.W_dstM = 4'h0; w.W_valM = 64'h5;
      step();
      w.w_valid = 0;
      chk("popq_we0", rf_we, 1);
      chk("popq_addr0", rf_waddr, 4'h4);
      chk("popq_data0", rf_wdata, 64'h108);
      chk("popq_cnt0", q_count, 1);
      step();
      chk("popq_addr1", rf_waddr, 4'h0);
      chk("popq_data1", rf_wdata, 64'h5);
      chk("popq_cnt1", q_count, 0);
      step();
      chk("popq_we2", rf_we, 0);

      // cmov not taken, then taken
      w.w_valid = 1; w.W_icode = 4'h2; w.W_Cnd = 0;
      w.W_dstE = 4'h3; w.W_valE = 64'h33; w.W_dstM = 4'hF;
      step();
      w.w_valid = 0;
      chk("cmov_nt_we", rf_we, 0);
      w.w_valid = 1; w.W_Cnd = 1;
      step();
      w.w_valid = 0;
      chk("cmov_t_we", rf_we, 1);
      chk("cmov_t_addr", rf_waddr, 4'h3);
      idle(3);

      // three back-to-back dual writes
      log_q.delete();
      send(4'h6, 0, 4'h1, 64'h101, 4'h2, 64'h102, s1);
      send(4'h6, 0, 4'h3, 64'h103, 4'h4, 64'h104, s2);
      send(4'h6, 0, 4'h5, 64'h105, 4'h6, 64'h106, s3);
      idle(6);
      chk("b2b_stall1", s1, 0);
      chk("b2b_stall2", s2, 0);
      chk("b2b_stall3", s3, 1);
      chk("b2b_count", log_q.size(), 6);
      for (int i = 0; i < 6 && i < log_q.size(); i++) begin
         chk("b2b_order", log_q[i].a, i + 1);
         chk("b2b_data", log_q[i].d, 64'h101 + i);
      end

      // lookup of queued r1 values, youngest wins
      send(4'h6, 0, 4'h5, 64'h55, 4'h6, 64'h66, s1);
      send(4'h6, 0, 4'h1, 64'hA, 4'h1, 64'hB, s2);
      w.w_valid = 0;
      lk_addr = 4'h1;
      #1;
      chk("lk_r1_hit", lk_hit, 1);
      chk("lk_r1_data", lk_data, 64'hB);
      lk_addr = 4'hF;
      #1;
      chk("lk_none_hit", lk_hit, 0);
      lk_addr = 4'h6;
      #1;
      chk("lk_rf_data", lk_data, 64'h66);
      idle(4);

      // debug starvation under continuous dual-write traffic
      log_q.delete();
      stop = 0;
      fork
         begin
            while (!stop)
               send(4'h6, 0, 4'h8, {$urandom, $urandom},
                    4'h9, {$urandom, $urandom}, s1);
            w.w_valid = 0;
         end
         begin
            dbg_req = 1; dbg_addr = 4'h7; dbg_data = 64'h77;
            n = 0;
            while (n < 60) begin
               @(negedge clk);
               n++;
               if (dbg_gnt) break;
            end
            @(posedge clk);
            #1;
            dbg_req = 0;
            stop = 1;
         end
      join
      chk("force_wait", (n >= STARVE + 1) && (n <= STARVE + 1 + DEPTH), 1);
      idle(6);
      k = 0;
      foreach (log_q[i])
         if (log_q[i].a == 4'h7) begin
            k++;
            chk("force_dbg_data", log_q[i].d, 64'h77);
         end
      chk("force_dbg_once", k, 1);

      // reset with two queued writes
      send(4'h6, 0, 4'h1, 64'h1, 4'h2, 64'h2, s1);
      send(4'h6, 0, 4'h3, 64'h3, 4'h4, 64'h4, s2);
      w.w_valid = 0;
      #1;
      chk("prerst_q_count", q_count, 2);
      rst_n = 0;
      #1;
      chk("rst_mid_we", rf_we, 0);
      chk("rst_mid_addr", rf_waddr, 4'hF);
      chk("rst_mid_data", rf_wdata, 0);
      chk("rst_mid_cnt", q_count, 0);
      step();
      step();
      rst_n = 1;
      log_q.delete();
      idle(5);
      chk("rst_no_write", log_q.size(), 0);

      // random traffic against the model
      for (int c = 0; c < 600; c++) begin
         if (!w.w_valid || !stall_last) begin
            w.w_valid = ($urandom % 4) != 0;
            case ($urandom % 5)
               0, 1: w.W_icode = 4'h2;
               2: w.W_icode = 4'hB;
               3: w.W_icode = 4'h6;
               default: w.W_icode = 4'h5;
            endcase
            w.W_Cnd = $urandom % 2;
            w.W_dstE = ($urandom % 4 == 0) ? 4'hF : 4'($urandom % 15);
            w.W_dstM = ($urandom % 3 == 0) ? 4'hF : 4'($urandom % 15);
            w.W_valE = {$urandom, $urandom};
            w.W_valM = {$urandom, $urandom};
         end
         if (dbg_req && gnt_last)
            dbg_req = 0;
         else if (!dbg_req && $urandom % 6 == 0) begin
            dbg_req = 1;
            dbg_addr = 4'($urandom % 16);
            dbg_data = {$urandom, $urandom};
         end
         lk_addr = 4'($urandom % 16);
         step();
      end
      w.w_valid = 0;
      n = 0;
      while (dbg_req && n < 30) begin
         if (gnt_last)
            dbg_req = 0;
         else
            step();
         n++;
      end
      if (dbg_req)
         chk("final_dbg_grant", 0, 1);
      dbg_req = 0;
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
